sprite_blitter: RTL and testbench

- Parametrised successor of the full-screen single-bit sprite renderer.
- Draws one positionable sprite of SPR_W x SPR_H pixels with multi-bit palette indices, run-time integer scale (1-4), horizontal flip and a transparent index.
- Emits RGB plus an opaque flag for a downstream compositor.
- Sprite-local coordinates come from incremental counters only: no dividers, no run-time multipliers.
- Sprite ROM and palette are external. The ROM has synchronous 1-cycle read on posedge vga_clk; the palette is combinational.

---
 rtl/sprite_blitter.sv | 143 ++++++++++++++
 tb/tb_sprite_blitter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Positionable, scalable, flippable sprite renderer with a fixed 3-cycle
// pixel pipeline: address register -> external sync ROM -> colour register.
module sprite_blitter #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int IDX_W      = 2,
  parameter int COLOR_W    = 4,
  parameter int TRANSP_IDX = 0,
  parameter int LATCH_LINE = 480,
  parameter int ADDR_W     = $clog2(SPR_W*SPR_H)
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic [1:0]         scale,
  input  logic               flip_x,
  input  logic               enable,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [COLOR_W-1:0] pal_red,
  input  logic [COLOR_W-1:0] pal_green,
  input  logic [COLOR_W-1:0] pal_blue,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               sprite_on
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(SPR_W);
  localparam logic [CW-1:0]     COL_LAST  = CW'(SPR_W-1);

  // shadow controls, only updated on the latch line so a frame never tears
  logic [9:0] px, py;
  logic [1:0] sc;
  logic       flip, en;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      px <= '0; py <= '0; sc <= '0; flip <= 1'b0; en <= 1'b0;
    end else if (DrawX == 10'd0 && DrawY == 10'(LATCH_LINE)) begin
      px <= pos_x; py <= pos_y; sc <= scale; flip <= flip_x; en <= enable;
    end
  end

  logic [11:0] span_x, span_y;
  always_comb begin
    case (sc)
      2'd0:    begin span_x = 12'(SPR_W);   span_y = 12'(SPR_H);   end
      2'd1:    begin span_x = 12'(2*SPR_W); span_y = 12'(2*SPR_H); end
      2'd2:    begin span_x = 12'(3*SPR_W); span_y = 12'(3*SPR_H); end
      default: begin span_x = 12'(4*SPR_W); span_y = 12'(4*SPR_H); end
    endcase
  end

  logic hx, vy, on_screen, hit_c;
  assign hx = ({2'b00, DrawX} >= {2'b00, px}) && ({2'b00, DrawX} < ({2'b00, px} + span_x));
  assign vy = ({2'b00, DrawY} >= {2'b00, py}) && ({2'b00, DrawY} < ({2'b00, py} + span_y));
  assign on_screen = (px < 10'd640) && (py < 10'd480);
  assign hit_c = hx && vy && en && on_screen;

  // counters: *_q is the previous pixel's value, *_c this pixel's value
  logic [CW-1:0] col_q, col_c;
  logic [RW-1:0] row_q, row_c;
  logic [1:0]    subx_q, subx_c, suby_q, suby_c;

  always_comb begin
    col_c  = col_q;
    subx_c = subx_q;
    if (DrawX == px) begin
      col_c  = '0;
      subx_c = '0;
    end else if (subx_q == sc) begin
      subx_c = '0;
      col_c  = col_q + 1'b1;
    end else begin
      subx_c = subx_q + 2'd1;
    end
  end

  always_comb begin
    row_c  = row_q;
    suby_c = suby_q;
    if (DrawX == 10'd0) begin
      if (DrawY == py) begin
        row_c  = '0;
        suby_c = '0;
      end else if (vy) begin
        if (suby_q == sc) begin
          suby_c = '0;
          row_c  = row_q + 1'b1;
        end else begin
          suby_c = suby_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      col_q <= '0; subx_q <= '0; row_q <= '0; suby_q <= '0;
    end else begin
      col_q <= col_c; subx_q <= subx_c; row_q <= row_c; suby_q <= suby_c;
    end
  end

  logic [CW-1:0]     ecol;
  logic [ADDR_W-1:0] addr_c;
  assign ecol   = flip ? (COL_LAST - col_c) : col_c;
  assign addr_c = ADDR_W'(row_c) * ROW_PITCH + ADDR_W'(ecol);

  // vld_pipe[k] = hit && blank for the pixel presented k cycles ago
  logic [2:1] vld_pipe;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      vld_pipe    <= '0;
    end else begin
      if (hit_c) rom_address <= addr_c;
      vld_pipe <= {vld_pipe[1], hit_c & blank};
    end
  end

  assign pal_index = rom_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      red <= '0; green <= '0; blue <= '0; sprite_on <= 1'b0;
    end else if (vld_pipe[2] && rom_q != IDX_W'(TRANSP_IDX)) begin
      red <= pal_red; green <= pal_green; blue <= pal_blue; sprite_on <= 1'b1;
    end else begin
      red <= '0; green <= '0; blue <= '0; sprite_on <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: drives short scan lines, models the ROM
// and palette, and compares every recorded pixel against a reference formula.
module tb_sprite_blitter;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, flip_x, enable;
  logic [1:0] scale;
  logic [9:0] rom_address;
  logic [1:0] rom_q = 2'd0;
  logic [1:0] pal_index;
  logic [3:0] pal_red, pal_green, pal_blue, red, green, blue;
  logic       sprite_on;

  sprite_blitter dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .flip_x(flip_x), .enable(enable),
    .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .sprite_on(sprite_on)
  );

  always #5 vga_clk = ~vga_clk;

  logic [1:0] rom [0:1023];
  always @(posedge vga_clk) rom_q <= rom[rom_address];

  assign pal_red   = {pal_index, 2'b01};
  assign pal_green = {2'b10, pal_index};
  assign pal_blue  = 4'(pal_index) + 4'd5;

  int passed = 0;
  int total  = 0;
  int m_px, m_py, m_s, m_flip, m_en;

  logic [12:0] obs_pix  [0:1023];
  logic [9:0]  obs_addr [0:1023];
  logic        in_bl    [0:1023];

  function automatic logic [12:0] exp_pix(input int x, input int y, input logic bl);
    int col, row, ec;
    logic [1:0] idx;
    if (!bl || m_en == 0 || m_px > 639 || m_py > 479 || x < m_px || x >= m_px + 32*m_s ||
        y < m_py || y >= m_py + 32*m_s) return 13'h0;
    col = (x - m_px) / m_s;
    row = (y - m_py) / m_s;
    ec  = (m_flip != 0) ? 31 - col : col;
    idx = rom[row*32 + ec];
    if (idx == 2'd0) return 13'h0;
    return {1'b1, idx, 2'b01, 2'b10, idx, 4'(idx) + 4'd5};
  endfunction

  task automatic step(input int x, input int y, input logic bl);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    @(posedge vga_clk); #1;
  endtask

  // pixel presented at step k shows on the outputs after step k+2
  task automatic scan_line(input int y, input int n, input int bx0, input int bx1);
    logic bl;
    for (int x = 0; x <= n + 2; x++) begin
      bl = (x < 640) && (y < 480) && !(x >= bx0 && x <= bx1);
      if (x <= n) in_bl[x] = bl;
      step(x, y, bl);
      if (x <= n) obs_addr[x] = rom_address;
      if (x >= 2) obs_pix[x-2] = {sprite_on, red, green, blue};
    end
  endtask

  task automatic latch();
    step(0, 480, 1'b0);
    m_px = int'(pos_x); m_py = int'(pos_y); m_s = int'(scale) + 1;
    m_flip = int'(flip_x); m_en = int'(enable);
  endtask

  task automatic init_rom();
    for (int a = 0; a < 1024; a++) rom[a] = 2'((a % 3) + 1);
  endtask

  task automatic test_reset();
    logic [12:0] e;
    reset = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1;
    total++;
    if ({sprite_on, red, green, blue} !== 13'h0) $display("FAIL reset_out got %h want 0", {sprite_on, red, green, blue});
    else passed++;
    total++;
    if (rom_address !== 10'd0) $display("FAIL reset_addr got %0d want 0", rom_address);
    else passed++;
    reset = 1'b0;
    // controls presented but never latched: nothing may appear
    pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; flip_x = 1'b0; enable = 1'b1;
    scan_line(50, 140, -1, -1);
    for (int x = 0; x <= 140; x++) begin
      e = exp_pix(x, 50, in_bl[x]);
      total++;
      if (obs_pix[x] !== e) $display("FAIL prelatch_pix x=%0d got %h want %h", x, obs_pix[x], e);
      else passed++;
    end
  endtask

  task automatic test_1x();
    logic [12:0] e;
    pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; flip_x = 1'b0; enable = 1'b1;
    latch();
    for (int y = 50; y <= 82; y++) begin
      scan_line(y, 140, -1, -1);
      for (int x = 0; x <= 140; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL 1x_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
      if (y == 52) begin
        total++;
        if (obs_addr[105] !== 10'd69) $display("FAIL 1x_addr got %0d want 69", obs_addr[105]);
        else passed++;
      end
      if (y == 50) begin
        total++;
        if (obs_addr[135] !== 10'd31) $display("FAIL 1x_addr_hold got %0d want 31", obs_addr[135]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    for (int x = 0; x <= 110; x++) step(x, 50, 1'b1);
    total++;
    if (sprite_on !== 1'b1) $display("FAIL midreset_pre got %b want 1", sprite_on);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({sprite_on, red, green, blue} !== 13'h0) $display("FAIL midreset_out got %h want 0", {sprite_on, red, green, blue});
    else passed++;
    total++;
    if (rom_address !== 10'd0) $display("FAIL midreset_addr got %0d want 0", rom_address);
    else passed++;
    repeat (2) @(posedge vga_clk);
    #1 reset = 1'b0;
    m_en = 0;
    scan_line(50, 140, -1, -1);
    for (int x = 0; x <= 140; x++) begin
      e = exp_pix(x, 50, in_bl[x]);
      total++;
      if (obs_pix[x] !== e) $display("FAIL postreset_pix x=%0d got %h want %h", x, obs_pix[x], e);
      else passed++;
    end
  endtask

  task automatic test_scale3_flip();
    logic [12:0] e;
    pos_x = 10'd200; pos_y = 10'd100; scale = 2'd2; flip_x = 1'b1; enable = 1'b1;
    latch();
    for (int y = 100; y <= 196; y++) begin
      scan_line(y, 300, -1, -1);
      for (int x = 0; x <= 300; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL 3x_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
      if (y == 100 || y == 103) begin
        for (int x = 200; x <= 202; x++) begin
          total++;
          if (obs_addr[x] !== ((y == 100) ? 10'd31 : 10'd63))
            $display("FAIL 3x_addr x=%0d y=%0d got %0d want %0d", x, y, obs_addr[x], (y == 100) ? 31 : 63);
          else passed++;
        end
      end
      if (y == 150) begin
        total++;
        if (obs_pix[295][12] !== 1'b1 || obs_pix[296][12] !== 1'b0)
          $display("FAIL 3x_edge got %b%b want 10", obs_pix[295][12], obs_pix[296][12]);
        else passed++;
      end
    end
  endtask

  task automatic test_transp();
    logic [12:0] e;
    rom[0] = 2'd0;
    pos_x = 10'd0; pos_y = 10'd0; scale = 2'd0; flip_x = 1'b0; enable = 1'b1;
    latch();
    for (int y = 0; y <= 1; y++) begin
      scan_line(y, 40, -1, -1);
      for (int x = 0; x <= 40; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL transp_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
      if (y == 0) begin
        total++;
        if (obs_pix[0] !== 13'h0 || obs_pix[1][12] !== 1'b1)
          $display("FAIL transp_edge got %h/%b want 0/1", obs_pix[0], obs_pix[1][12]);
        else passed++;
      end else begin
        total++;
        if (obs_addr[0] !== 10'd32) $display("FAIL transp_col0 got %0d want 32", obs_addr[0]);
        else passed++;
      end
    end
    rom[0] = 2'd1;
  endtask

  task automatic test_tear();
    logic [12:0] e;
    pos_x = 10'd100; pos_y = 10'd198; scale = 2'd0; flip_x = 1'b0; enable = 1'b1;
    latch();
    for (int y = 198; y <= 203; y++) begin
      if (y == 200) pos_x = 10'd300;
      scan_line(y, 340, -1, -1);
      for (int x = 0; x <= 340; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL tear_old_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
    end
    total++;
    if (obs_pix[100][12] !== 1'b1 || obs_pix[300][12] !== 1'b0)
      $display("FAIL tear_old got %b%b want 10", obs_pix[100][12], obs_pix[300][12]);
    else passed++;
    latch();
    for (int y = 198; y <= 199; y++) begin
      scan_line(y, 340, -1, -1);
      for (int x = 0; x <= 340; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL tear_new_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
    end
    total++;
    if (obs_pix[300][12] !== 1'b1 || obs_pix[100][12] !== 1'b0)
      $display("FAIL tear_new got %b%b want 10", obs_pix[300][12], obs_pix[100][12]);
    else passed++;
  endtask

  task automatic test_clip_blank();
    logic [12:0] e;
    pos_x = 10'd620; pos_y = 10'd400; scale = 2'd1; flip_x = 1'b0; enable = 1'b1;
    latch();
    for (int y = 400; y <= 402; y++) begin
      if (y == 402) scan_line(y, 700, 625, 630);
      else          scan_line(y, 700, -1, -1);
      for (int x = 0; x <= 700; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL clip_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
      if (y == 401) begin
        total++;
        if (obs_pix[639][12] !== 1'b1 || obs_pix[640][12] !== 1'b0)
          $display("FAIL clip_edge got %b%b want 10", obs_pix[639][12], obs_pix[640][12]);
        else passed++;
      end
      if (y == 402) begin
        total++;
        if (obs_pix[627] !== 13'h0 || obs_pix[624][12] !== 1'b1)
          $display("FAIL blank_gate got %h/%b want 0/1", obs_pix[627], obs_pix[624][12]);
        else passed++;
      end
    end
  endtask

  task automatic test_offscreen();
    logic [12:0] e;
    pos_x = 10'd700; pos_y = 10'd10; scale = 2'd0; flip_x = 1'b0; enable = 1'b1;
    latch();
    for (int y = 10; y <= 11; y++) begin
      scan_line(y, 799, -1, -1);
      for (int x = 0; x <= 799; x++) begin
        e = exp_pix(x, y, in_bl[x]);
        total++;
        if (obs_pix[x] !== e) $display("FAIL offscreen_pix x=%0d y=%0d got %h want %h", x, y, obs_pix[x], e);
        else passed++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
    pos_x = '0; pos_y = '0; scale = '0; flip_x = 1'b0; enable = 1'b0;
    m_px = 0; m_py = 0; m_s = 1; m_flip = 0; m_en = 0;
    init_rom();
    test_reset();
    test_1x();
    test_reset_mid();
    test_scale3_flip();
    test_transp();
    test_tear();
    test_clip_blank();
    test_offscreen();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
